midi_tx: RTL and testbench

- Serial byte transmitter for the synth's MIDI/serial output line; the transmit counterpart of the input glitch filter on the receive pin.
- Accepts bytes over a valid/ready handshake and serialises each as 8N1: 1 start, 8 data LSB-first, 1 stop.
- Bit timing comes from an internal clock divider.
- Output drives the pin directly; line idles high.

---
 rtl/midi_pkg.sv | 23 ++
 rtl/midi_tx_fifo.sv | 62 ++++++
 rtl/midi_tx.sv | 131 +++++++++++++
 tb/tb_midi_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// ============================================================================
// Module   : midi_pkg
// Brief    : Shared types and timing constants for the MIDI transmit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int MIDI_BAUD            = 31250;
    localparam int SYS_CLK_HZ           = 50000000;
    localparam int CLKS_PER_BIT_DEFAULT = SYS_CLK_HZ / MIDI_BAUD;

endpackage

`default_nettype wire

// File: rtl/midi_tx_fifo.sv
// ============================================================================
// Module   : midi_tx_fifo
// Brief    : Small register FIFO buffering bytes ahead of the serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_tx_fifo
    import midi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/midi_tx.sv
// ============================================================================
// Module   : midi_tx
// Brief    : 8N1 serial byte transmitter for the MIDI output pin.
//            Define MIDI_TX_FIFO_EN to add a 4-entry input FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] c_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    c_IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [CW-1:0]        r_baud;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_out;
    logic                 r_busy;
    logic                 w_start;
    logic [DATA_BITS-1:0] w_byte;
    logic                 w_bit_end;

    assign w_bit_end = (r_baud == c_BIT_LAST);
    assign o_out     = r_out;

`ifdef MIDI_TX_FIFO_EN
    logic w_full;
    logic w_empty;

    assign w_start    = (r_state == IDLE) && !w_empty;
    assign o_tx_ready = !w_full;
    assign o_tx_busy  = r_busy || !w_empty;

    midi_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_tx_valid),
        .i_data  (i_tx_data),
        .i_pop   (w_start),
        .o_data  (w_byte),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    logic r_ready;

    assign w_start    = i_tx_valid && r_ready;
    assign w_byte     = i_tx_data;
    assign o_tx_ready = r_ready;
    assign o_tx_busy  = r_busy;

    // Ready returns together with IDLE, giving one extra stop cycle between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_ready <= 1'b1;
        else if (w_start)                          r_ready <= 1'b0;
        else if ((r_state == STOP) && w_bit_end)   r_ready <= 1'b1;
    end
`endif

    // The line is driven from the state one cycle later, so each bit keeps full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_baud <= r_baud + CW'(1);
            case (r_state)
                IDLE: begin
                    r_out  <= 1'b1;
                    r_baud <= '0;
                    if (w_start) begin
                        r_shift <= w_byte;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_out <= 1'b0;
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_out <= r_shift[0];
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_idx == c_IDX_LAST) r_state <= STOP;
                        else                     r_idx   <= r_idx + 3'd1;
                    end
                end
                STOP: begin
                    r_out <= 1'b1;
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_midi_tx.sv
// ============================================================================
// Module   : tb_midi_tx
// Brief    : Self-checking bench for midi_tx at 4 clocks per bit.
//            MIDI_TX_FIFO_EN selects the FIFO variant of the checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_tx;

    localparam int CPB = 4;
`ifdef MIDI_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       busy;
    logic       out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic [9:0] line;   // frame bits, bit 0 transmitted first
    } vec_t;

    vec_t vecs [5];

    midi_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_data  (data),
        .i_tx_valid (valid),
        .o_tx_ready (ready),
        .o_tx_busy  (busy),
        .o_out      (out)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge just before the accept edge.
    task automatic capture(input logic [9:0] exp, input bit hold,
                           input logic [7:0] da, input logic [7:0] db, input string name);
        int rdy_low = 0;
        int busy_hi = 0;
        int lat_bad = 0;
        int bit_bad;
        for (int l = 0; l < LAT; l++) begin
            @(negedge clk);
            if (l == 0) begin
                if (!hold) valid = 1'b0;
                data = da;
            end
            if (!ready) rdy_low++;
            if (busy)   busy_hi++;
            if (out !== 1'b1) lat_bad++;
        end
        chk({name, "_latency"}, lat_bad, 0);
        for (int b = 0; b < 10; b++) begin
            bit_bad = 0;
            for (int s = 0; s < CPB; s++) begin
                @(negedge clk);
                if (b == 5 && s == 0) data = db;
                if (!ready) rdy_low++;
                if (busy)   busy_hi++;
                if (out !== exp[b]) bit_bad++;
            end
            chk($sformatf("%s_bit%0d", name, b), bit_bad, 0);
        end
`ifndef MIDI_TX_FIFO_EN
        chk({name, "_ready_low"}, rdy_low, 10 * CPB);
`endif
        chk({name, "_busy_hi"}, busy_hi, 10 * CPB + LAT - 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] exp, input bit hold,
                        input logic [7:0] da, input logic [7:0] db, input string name);
        int t = 0;
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk({name, "_ready_wait"}, 0, 1);
        capture(exp, hold, da, db, name);
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'h90, 10'b1100100000};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h01, 10'b1000000010};

        // Reset held: values must already be the reset ones.
        @(negedge clk);
        chk("rst_out", int'(out), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle50", bad, 0);

        for (int i = 0; i < 5; i++)
            send(vecs[i].d, vecs[i].line, 1'b0, 8'hE7 ^ 8'(i), 8'h5A, $sformatf("vec%0d", i));

`ifndef MIDI_TX_FIFO_EN
        // Back-to-back with valid held: one idle-high cycle between frames.
        send(8'h3C, 10'b1001111000, 1'b1, 8'h7F, 8'h7F, "b2b_a");
        capture(10'b1011111110, 1'b0, 8'hC3, 8'hC3, "b2b_b");

        // Data changes while waiting; the value at the accept edge is sent.
        send(8'hA5, 10'b1101001010, 1'b1, 8'h11, 8'h22, "chg_a");
        capture(10'b1001000100, 1'b0, 8'h99, 8'h99, "chg_b");

        // Abort during data bit 3, for a high and a low bit.
        for (int a = 0; a < 2; a++) begin
            logic [7:0] ab;
            ab = (a == 0) ? 8'hFF : 8'h00;
            repeat (3) @(negedge clk);
            data  = ab;
            valid = 1'b1;
            @(posedge clk);
            #1 valid = 1'b0;
            repeat (18) @(negedge clk);
            chk($sformatf("abort%0d_prebit3", a), int'(out), int'(ab[3]));
            #1 rst_n = 1'b0;
            #1;
            chk($sformatf("abort%0d_out", a), int'(out), 1);
            chk($sformatf("abort%0d_ready", a), int'(ready), 1);
            chk($sformatf("abort%0d_busy", a), int'(busy), 0);
            @(negedge clk);
            rst_n = 1'b1;
            bad = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
            end
            chk($sformatf("abort%0d_noresume", a), bad, 0);
        end
        send(8'h01, 10'b1000000010, 1'b0, 8'h00, 8'h00, "post_abort");
`else
        begin
            logic [7:0] fb [5];
            logic       oq [260];
            logic       bq [260];
            int         pos;
            int         st;
            int         last_st;
            logic [7:0] got;
            fb[0] = 8'h90; fb[1] = 8'h3C; fb[2] = 8'h7F; fb[3] = 8'hA5; fb[4] = 8'h01;
            repeat (3) @(negedge clk);
            data  = fb[0];
            valid = 1'b1;
            fork
                begin
                    for (int p = 0; p < 5; p++) begin
                        if (p > 0) @(negedge clk);
                        data = fb[p];
                        chk($sformatf("fifo_ready_push%0d", p), int'(ready), 1);
                        @(posedge clk);
                    end
                    @(negedge clk);
                    valid = 1'b0;
                    chk("fifo_ready_full", int'(ready), 0);
                end
                begin
                    for (int i = 0; i < 260; i++) begin
                        @(negedge clk);
                        oq[i] = out;
                        bq[i] = busy;
                    end
                end
            join
            pos = 0;
            last_st = 0;
            for (int f = 0; f < 5; f++) begin
                st = -1;
                for (int i = pos; i < 220 && st < 0; i++)
                    if (oq[i] === 1'b0) st = i;
                if (st < 0) begin
                    chk($sformatf("fifo_frame%0d_found", f), 0, 1);
                    break;
                end
                if (f == 0) chk("fifo_first_start", st, 2);
                else        chk($sformatf("fifo_gap%0d", f), st - last_st, 41);
                got = '0;
                for (int b = 0; b < 8; b++) got[b] = oq[st + CPB * (b + 1) + 2];
                chk($sformatf("fifo_byte%0d", f), int'(got), int'(fb[f]));
                chk($sformatf("fifo_stop%0d", f), int'(oq[st + 38]), 1);
                last_st = st;
                pos = st + 40;
            end
            bad = 0;
            for (int i = 0; i <= last_st + 38; i++) if (bq[i] !== 1'b1) bad++;
            chk("fifo_busy_during", bad, 0);
            chk("fifo_busy_fall", int'(bq[last_st + 39]), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
